// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: produces per-stage stall/flush controls for load-use,
// taken branches, multi-cycle divides and data-memory wait states.
module hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] if_id_rs1_addr_i,
    input  logic [4:0] if_id_rs2_addr_i,
    input  logic [4:0] id_ex_rd_addr_i,
    input  logic       id_ex_write_rd_i,
    input  logic       id_ex_wb_use_mem_i,
    input  logic       ex_branch_taken_i,
    input  logic       ex_div_start_i,
    input  logic       dmem_req_i,
    input  logic       dmem_rvalid_i,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       stall_ex_o,
    output logic       stall_mem_o,
    output logic       flush_if_id_o,
    output logic       flush_id_ex_o,
    output logic       flush_ex_mem_o,
    output logic       flush_mem_wb_o,
    output logic       div_done_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

    state_e     state_q, state_d;
    logic [5:0] div_cnt_q, div_cnt_d;

    logic load_use_s, mem_wait_s, eval_run_s;
    logic stall_if_s, stall_id_s, stall_ex_s, stall_mem_s;
    logic flush_if_id_s, flush_id_ex_s, flush_ex_mem_s, flush_mem_wb_s;
    logic div_done_s;

    assign load_use_s = id_ex_wb_use_mem_i & id_ex_write_rd_i &
                        (id_ex_rd_addr_i != 5'd0) &
                        ((id_ex_rd_addr_i == if_id_rs1_addr_i) |
                         (id_ex_rd_addr_i == if_id_rs2_addr_i));
    assign mem_wait_s = dmem_req_i & ~dmem_rvalid_i;

    // Next-state and stall/flush decode
    always_comb begin
        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        eval_run_s     = 1'b0;
        stall_if_s     = 1'b0;
        stall_id_s     = 1'b0;
        stall_ex_s     = 1'b0;
        stall_mem_s    = 1'b0;
        flush_if_id_s  = 1'b0;
        flush_id_ex_s  = 1'b0;
        flush_ex_mem_s = 1'b0;
        flush_mem_wb_s = 1'b0;
        div_done_s     = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait_s) begin
                    {stall_if_s, stall_id_s, stall_ex_s, stall_mem_s} = 4'b1111;
                    flush_mem_wb_s = 1'b1;
                    state_d        = MEM_WAIT;
                end else begin
                    eval_run_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_rvalid_i) begin
                    {stall_if_s, stall_id_s, stall_ex_s, stall_mem_s} = 4'b1111;
                    flush_mem_wb_s = 1'b1;
                end else begin
                    eval_run_s = 1'b1;
                end
            end
            DIV_WAIT: begin
                // An older memory access holds MEM, so EX/MEM is held rather than bubbled
                if (mem_wait_s) begin
                    {stall_if_s, stall_id_s, stall_ex_s, stall_mem_s} = 4'b1111;
                    flush_mem_wb_s = 1'b1;
                    if (div_cnt_q != 6'd0) begin
                        div_cnt_d = div_cnt_q - 6'd1;
                    end else begin
                        div_cnt_d = 6'd0;
                    end
                end else if (div_cnt_q == 6'd0) begin
                    div_done_s = 1'b1;
                    state_d    = RUN;
                end else begin
                    {stall_if_s, stall_id_s, stall_ex_s} = 3'b111;
                    flush_ex_mem_s = 1'b1;
                    div_cnt_d      = div_cnt_q - 6'd1;
                end
            end
            default: begin
                state_d   = RUN;
                div_cnt_d = 6'd0;
            end
        endcase

        // Remaining RUN priorities, shared with the MEM_WAIT release cycle
        if (eval_run_s) begin
            state_d = RUN;
            if (ex_div_start_i) begin
                {stall_if_s, stall_id_s, stall_ex_s} = 3'b111;
                flush_ex_mem_s = 1'b1;
                div_cnt_d      = DIV_LOAD;
                state_d        = DIV_WAIT;
            end else if (ex_branch_taken_i) begin
                flush_if_id_s = 1'b1;
                flush_id_ex_s = 1'b1;
            end else if (load_use_s) begin
                stall_if_s    = 1'b1;
                stall_id_s    = 1'b1;
                flush_id_ex_s = 1'b1;
            end else begin
                stall_if_s = 1'b0;
            end
        end else begin
            eval_run_s = 1'b0;
        end
    end

    // State and divide counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            div_cnt_q <= 6'd0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // Outputs are forced low for the whole time reset is held
    assign stall_if_o     = stall_if_s     & ~rst_i;
    assign stall_id_o     = stall_id_s     & ~rst_i;
    assign stall_ex_o     = stall_ex_s     & ~rst_i;
    assign stall_mem_o    = stall_mem_s    & ~rst_i;
    assign flush_if_id_o  = flush_if_id_s  & ~rst_i;
    assign flush_id_ex_o  = flush_id_ex_s  & ~rst_i;
    assign flush_ex_mem_o = flush_ex_mem_s & ~rst_i;
    assign flush_mem_wb_o = flush_mem_wb_s & ~rst_i;
    assign div_done_o     = div_done_s     & ~rst_i;
    assign busy_o         = (state_q != RUN) & ~rst_i;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: DIV_CYCLES, default 32, number of EX cycles a multi-cycle divide occupies (legal range 2..63).
REQ-002 clk_i  in  1  single core clock, all state on rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 if_id_rs1_addr_i, if_id_rs2_addr_i  in  5 each  source registers of instruction in ID.
REQ-005 id_ex_rd_addr_i  in  5  destination of instruction in EX.
REQ-006 id_ex_write_rd_i, id_ex_wb_use_mem_i  in  1 each  EX instruction writes rd / is a load.
REQ-007 ex_branch_taken_i  in  1  EX resolved a taken branch or jump (redirect this cycle).
REQ-008 ex_div_start_i  in  1  EX holds a divide/remainder instruction.
REQ-009 dmem_req_i  in  1  MEM stage instruction accesses data memory this cycle.
REQ-010 dmem_rvalid_i  in  1  data memory completes the access this cycle.
REQ-011 stall_if_o, stall_id_o, stall_ex_o, stall_mem_o  out  1 each  hold the named stage's pipeline register.
REQ-012 flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o  out  1 each  load a bubble into the named pipeline register.
REQ-013 div_done_o  out  1  one-cycle pulse: divide result valid, EX may advance.
REQ-014 busy_o  out  1  FSM not in RUN.

Function
REQ-015 FSM states RUN, DIV_WAIT, MEM_WAIT; 6-bit down-counter div_cnt; state and div_cnt registered, all outputs combinational from state, div_cnt and inputs.
REQ-016 load_use = id_ex_wb_use_mem_i & id_ex_write_rd_i & (id_ex_rd_addr_i != 0) & (rd == if_id_rs1_addr_i | rd == if_id_rs2_addr_i).
REQ-017 mem_wait = dmem_req_i & !dmem_rvalid_i.
REQ-018 RUN evaluation, strict priority, first match only: (a) mem_wait -> assert stall_if/id/ex/mem, flush_mem_wb; next MEM_WAIT. (b) ex_div_start_i -> assert stall_if/id/ex, flush_ex_mem; div_cnt <= DIV_CYCLES-2; next DIV_WAIT. (c) ex_branch_taken_i -> assert flush_if_id, flush_id_ex; no stall; stay RUN. (d) load_use -> assert stall_if, stall_id, flush_id_ex; stay RUN. (e) none -> all outputs 0.
REQ-019 Divide occupies EX exactly DIV_CYCLES cycles: 1 entry cycle plus DIV_CYCLES-1 DIV_WAIT cycles.
REQ-020 DIV_WAIT, div_cnt != 0: stall_if/id/ex, flush_ex_mem asserted; div_cnt decrements; ex_div_start_i, branch, load_use ignored.
REQ-021 DIV_WAIT, div_cnt == 0: div_done_o = 1, stalls of IF/ID/EX released, flush_ex_mem = 0; next RUN.
REQ-022 DIV_WAIT with mem_wait true (older load/store in MEM): additionally assert stall_mem_o, flush_mem_wb_o, and stall_ex_o; div_cnt still decrements but never below 0; if div_cnt == 0 FSM holds DIV_WAIT with div_done_o = 0 until mem_wait clears.
REQ-023 MEM_WAIT, dmem_rvalid_i = 0: stall_if/id/ex/mem, flush_mem_wb asserted.
REQ-024 MEM_WAIT, dmem_rvalid_i = 1: MEM released; rules REQ-018 (b)-(e) evaluated as in RUN this cycle and determine outputs and next state.
REQ-025 Stall and flush of the same register never both asserted; flush of a register downstream of a stalled stage inserts the bubble.
REQ-026 busy_o = (state != RUN).

Reset
REQ-027 rst_i asserted (any cycle, including mid-divide or mid-memory-wait): state <= RUN, div_cnt <= 0 immediately.
REQ-028 While rst_i high, every output is 0 regardless of inputs.
REQ-029 First edge after rst_i deasserts follows RUN rules; no pending divide or memory wait is resumed.

Verification
REQ-030 Load-use: id_ex rd=5 load, if_id rs2=5 -> exactly one cycle stall_if=stall_id=flush_id_ex=1; rd=0 same case -> no stall.
REQ-031 Divide, DIV_CYCLES=4: ex_div_start_i held -> stall_ex high 3 cycles, div_done_o pulse in 4th cycle, busy_o high cycles 2-4.
REQ-032 Memory wait: dmem_req_i with rvalid after 3 cycles -> stall_mem/flush_mem_wb high 3 cycles, released in rvalid cycle.
REQ-033 Simultaneous mem_wait + ex_div_start_i + branch in RUN -> MEM_WAIT only; after rvalid, DIV_WAIT entered; branch flush only after div_done_o.
REQ-034 Reset mid-divide (div_cnt=10): rst_i pulse -> outputs 0 asynchronously, busy_o 0, RUN after release.
REQ-035 Branch taken with load_use true -> flush_if_id=flush_id_ex=1, stall_if=stall_id=0.
